pipe_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 3-stage RV32I pipeline (fetch / decode / execute+mem+writeback).
- Drives the enable, bubble and flush controls of the fetch/decode and decode/execute pipeline registers, and generates operand-forwarding selects.
- Sequences multi-cycle data-memory waits and branch/jump redirects.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward sequencing for the 3-stage RV32I pipeline,
// with memory-wait timeout and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_load,
    input  logic             ex_store,
    input  logic             ex_redirect,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_hold,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

    state_t        state, state_nx;
    logic [WW-1:0] wait_cnt, wait_nx;
    logic [FW-1:0] flush_cnt, flush_nx;
    logic          err_nx, mem_op, hit1, hit2, lu, timeout, mem_stall;

    assign mem_op    = ex_load | ex_store;
    assign hit1      = id_use_rs1 & (id_rs1 == ex_rd) & (ex_rd != 5'd0);
    assign hit2      = id_use_rs2 & (id_rs2 == ex_rd) & (ex_rd != 5'd0);
    assign lu        = ex_load & ex_reg_write & (hit1 | hit2);
    assign fwd_a     = !rst & ex_reg_write & !ex_load & hit1;
    assign fwd_b     = !rst & ex_reg_write & !ex_load & hit2;
    assign timeout   = (state == MEM_WAIT) & !mem_ready & (wait_cnt == WW'(MEM_TIMEOUT - 1));
    // Once waiting, the wait continues on !mem_ready alone until release or timeout.
    assign mem_stall = !mem_ready & !timeout & ((state == MEM_WAIT) | mem_op);

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        state_nx     = state;
        wait_nx      = wait_cnt;
        flush_nx     = flush_cnt;
        err_nx       = 1'b0;
        if (state == FLUSH) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_nx     = ex_redirect ? FW'(1) : flush_cnt + 1'b1;
            state_nx     = (!ex_redirect && flush_cnt == FW'(FLUSH_CYCLES - 1)) ? RUN : FLUSH;
        end else if (mem_stall) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            ex_hold  = 1'b1;
            state_nx = MEM_WAIT;
            wait_nx  = (state == MEM_WAIT) ? wait_cnt + 1'b1 : WW'(1);
        end else begin
            state_nx = RUN;
            err_nx   = timeout;
            if (ex_redirect) begin
                if_id_en     = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                if (FLUSH_CYCLES > 1 && !timeout) begin
                    state_nx = FLUSH;
                    flush_nx = FW'(1);
                end
            end else if (lu) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_hold      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            flush_cnt <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_nx;
            flush_cnt <= flush_nx;
            mem_err   <= err_nx;
            if (!pc_en && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed stimulus, per-cycle comparison against a countdown-style
// behavioural model, plus hand-computed literal expectations.
module tb_pipe_hazard_ctrl;
    localparam int FC = 2;
    localparam int TO = 16;
    localparam int CW = 4;

    logic          clk, rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_reg_write, ex_load, ex_store, ex_redirect, mem_ready;
    logic          pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_hold, fwd_a, fwd_b, mem_err;
    logic [CW-1:0] stall_cnt;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_load(ex_load),
        .ex_store(ex_store), .ex_redirect(ex_redirect), .mem_ready(mem_ready), .pc_en(pc_en),
        .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .ex_hold(ex_hold), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Model state: in_wait/age = memory wait in progress and its length,
    // flush_left = remaining dedicated flush cycles, stall = expected counter.
    bit       armed = 1'b0;
    bit       in_wait, m_err, nx_wait, nx_err;
    int       age, flush_left, m_stall, nx_age, nx_left;
    logic [6:0] exp_c;

    function automatic void model(output logic [6:0] c, output bit w, output int a,
                                  output int left, output bit err);
        bit memop, lu, fa, fb, tout;
        logic pc, en, fl, bub, hold;
        memop = ex_load || ex_store;
        lu = ex_load && ex_reg_write && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        fa = ex_reg_write && !ex_load && ex_rd != 0 && id_use_rs1 && id_rs1 == ex_rd;
        fb = ex_reg_write && !ex_load && ex_rd != 0 && id_use_rs2 && id_rs2 == ex_rd;
        w = 0; a = 0; left = 0; err = 0;
        pc = 1; en = 1; fl = 0; bub = 0; hold = 0;
        if (rst) begin
            c = 7'b0011000;
            return;
        end
        if (flush_left > 0) begin
            fl = 1; bub = 1;
            left = ex_redirect ? FC - 1 : flush_left - 1;
        end else begin
            tout = in_wait && !mem_ready && age == TO - 1;
            if (!mem_ready && !tout && (in_wait || memop)) begin
                pc = 0; en = 0; hold = 1;
                w = 1; a = in_wait ? age + 1 : 1;
            end else begin
                err = tout;
                if (ex_redirect) begin
                    en = 0; fl = 1; bub = 1;
                    left = tout ? 0 : FC - 1;
                end else if (lu) begin
                    pc = 0; en = 0; bub = 1;
                end
            end
        end
        c = {pc, en, fl, bub, hold, fa, fb};
    endfunction

    always @(negedge clk) begin
        model(exp_c, nx_wait, nx_age, nx_left, nx_err);
        if (armed) begin
            vectors++;
            if ({pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_hold, fwd_a, fwd_b} !== exp_c ||
                mem_err !== m_err || stall_cnt !== CW'(m_stall)) begin
                errors++;
                $display("FAIL cycle t=%0t: ctrl=%b err=%b stall=%0d, required ctrl=%b err=%b stall=%0d",
                         $time, {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_hold, fwd_a, fwd_b},
                         mem_err, stall_cnt, exp_c, m_err, m_stall);
            end
        end
    end

    always @(posedge clk) begin
        armed <= 1'b1;
        if (rst) begin
            in_wait <= 0; age <= 0; flush_left <= 0; m_err <= 0; m_stall <= 0;
        end else begin
            in_wait    <= nx_wait;
            age        <= nx_age;
            flush_left <= nx_left;
            m_err      <= nx_err;
            if (!exp_c[6] && m_stall < (1 << CW) - 1)
                m_stall <= m_stall + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0;
        ex_reg_write = 0; ex_load = 0; ex_store = 0; ex_redirect = 0; mem_ready = 1;
    endtask

    task automatic next();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic lu_setup(input logic [4:0] rd);
        ex_load = 1; ex_reg_write = 1; ex_rd = rd; id_rs2 = 5; id_use_rs2 = 1;
    endtask

    typedef struct { logic [4:0] rd, rs1, rs2; logic u1, u2, wr, ld; } vec_t;
    vec_t tbl[6] = '{
        '{5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0},
        '{5'd4, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0},
        '{5'd9, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0},
        '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0},
        '{5'd8, 5'd8, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1},
        '{5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1}
    };

    initial begin
        int first;
        idle(); rst = 1; ex_redirect = 1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_flush", if_id_flush, 1);
        chk("rst_bubble", id_ex_bubble, 1);
        chk("rst_stall", stall_cnt, 0);
        next(); @(negedge clk);
        chk("run_pc_en", pc_en, 1);
        chk("run_if_id_en", if_id_en, 1);
        // load-use, then same with x0 destination
        next(); lu_setup(5); @(negedge clk);
        chk("lu_pc_en", pc_en, 0);
        chk("lu_bubble", id_ex_bubble, 1);
        next(); @(negedge clk);
        chk("lu_stall", stall_cnt, 1);
        next(); lu_setup(0); @(negedge clk);
        chk("lu_x0_pc_en", pc_en, 1);
        // forwarding both operands
        next(); ex_reg_write = 1; ex_rd = 7; id_rs1 = 7; id_rs2 = 7; id_use_rs1 = 1; id_use_rs2 = 1;
        @(negedge clk);
        chk("fwd_a", fwd_a, 1);
        chk("fwd_b", fwd_b, 1);
        chk("fwd_pc_en", pc_en, 1);
        // memory wait of 4 cycles
        for (int i = 0; i < 4; i++) begin
            next(); ex_store = 1; mem_ready = 0; @(negedge clk);
            chk("mw_hold", ex_hold, 1);
            chk("mw_pc_en", pc_en, 0);
        end
        next(); ex_store = 1; @(negedge clk);
        chk("mw_release", pc_en, 1);
        chk("mw_release_hold", ex_hold, 0);
        next(); @(negedge clk);
        chk("mw_stall", stall_cnt, 5);
        // timeout: mem_err one cycle after the 15th waiting cycle
        next(); ex_load = 1; mem_ready = 0;
        first = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 15) chk("to_pc_en", pc_en, 1);
            if (first >= 0 && i == first + 1) begin
                chk("to_pulse_end", mem_err, 0);
                break;
            end
            if (mem_err === 1'b1 && first < 0) first = i;
            @(posedge clk); #1;
        end
        chk("to_err_cycle", first, 16);
        next(); @(negedge clk);
        chk("stall_sat", stall_cnt, 15);
        // redirect with two flush cycles
        next(); ex_redirect = 1; @(negedge clk);
        chk("rd_flush0", if_id_flush, 1);
        next(); @(negedge clk);
        chk("rd_flush1", if_id_flush, 1);
        next(); @(negedge clk);
        chk("rd_flush_end", if_id_flush, 0);
        // redirect wins over load-use
        next(); ex_redirect = 1; lu_setup(5); @(negedge clk);
        chk("rdlu_pc_en", pc_en, 1);
        chk("rdlu_flush", if_id_flush, 1);
        next(); lu_setup(5); @(negedge clk);
        chk("rdlu_flush1", if_id_flush, 1);
        // reset mid wait
        next(); ex_store = 1; mem_ready = 0;
        next(); ex_store = 1; mem_ready = 0; @(negedge clk);
        chk("mr_hold", ex_hold, 1);
        next(); rst = 1; ex_store = 1; mem_ready = 0; @(negedge clk);
        chk("mr_rst_hold", ex_hold, 0);
        chk("mr_rst_pc_en", pc_en, 0);
        next(); @(negedge clk);
        chk("mr_after_pc_en", pc_en, 1);
        chk("mr_after_stall", stall_cnt, 0);
        // release with pending redirect
        next(); ex_store = 1; mem_ready = 0;
        next(); ex_store = 1; ex_redirect = 1; @(negedge clk);
        chk("rel_rd_flush", if_id_flush, 1);
        next(); @(negedge clk);
        chk("rel_rd_flush1", if_id_flush, 1);
        for (int i = 0; i < 6; i++) begin
            next();
            ex_rd = tbl[i].rd; id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; id_use_rs1 = tbl[i].u1;
            id_use_rs2 = tbl[i].u2; ex_reg_write = tbl[i].wr; ex_load = tbl[i].ld;
        end
        next();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
